// File: rtl/qm_decode_stage_if.sv
// qm_decode_stage_if: bundles every decode-stage signal except clock/reset.
//   master : the surrounding pipeline (fetch, control unit, writeback, execute)
//            drives di_*/ci_* and observes o_*/do_*/co_*.
//   slave  : the decode stage itself.
// Parameters: DATA_WIDTH (operand/immediate width), REG_AW (register address width).
interface qm_decode_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 5
);
    // Fetch / writeback / control-unit inputs
    logic [31:0]            di_IR;
    logic                   di_IRValid;
    logic [REG_AW-1:0]      di_WA;
    logic                   di_WE;
    logic [DATA_WIDTH-1:0]  di_WD;
    logic                   ci_RegWrite, ci_MemRead, ci_MemWrite;
    logic                   ci_ALUSource, ci_RegDest, ci_ZeroExt;
    logic [3:0]             ci_ALUControl;
    logic                   ci_Stall, ci_Flush;
    // Combinational outputs
    logic [5:0]             o_Opcode, o_Function;
    logic                   o_StallFetch;
    // ID/EX registered outputs
    logic [DATA_WIDTH-1:0]  do_RSVal, do_RTVal, do_Imm;
    logic [REG_AW-1:0]      do_RS, do_RT, do_RD;
    logic                   do_Valid;
    logic                   co_RegWrite, co_MemRead, co_MemWrite;
    logic                   co_ALUSource, co_RegDest;
    logic [3:0]             co_ALUControl;

    modport master (
        output di_IR, di_IRValid, di_WA, di_WE, di_WD,
               ci_RegWrite, ci_MemRead, ci_MemWrite, ci_ALUSource, ci_RegDest,
               ci_ZeroExt, ci_ALUControl, ci_Stall, ci_Flush,
        input  o_Opcode, o_Function, o_StallFetch,
               do_RSVal, do_RTVal, do_Imm, do_RS, do_RT, do_RD, do_Valid,
               co_RegWrite, co_MemRead, co_MemWrite, co_ALUSource, co_RegDest,
               co_ALUControl
    );

    modport slave (
        input  di_IR, di_IRValid, di_WA, di_WE, di_WD,
               ci_RegWrite, ci_MemRead, ci_MemWrite, ci_ALUSource, ci_RegDest,
               ci_ZeroExt, ci_ALUControl, ci_Stall, ci_Flush,
        output o_Opcode, o_Function, o_StallFetch,
               do_RSVal, do_RTVal, do_Imm, do_RS, do_RT, do_RD, do_Valid,
               co_RegWrite, co_MemRead, co_MemWrite, co_ALUSource, co_RegDest,
               co_ALUControl
    );
endinterface

// File: rtl/qm_decode_stage.sv
// qm_decode_stage: MIPS decode stage.
//   Register file with write-to-read bypass, immediate extension, load-use
//   hazard detection and a registered ID/EX boundary with stall and flush.
// Ports:
//   clk     : clock
//   reset_n : asynchronous active-low reset (clears regfile and ID/EX)
//   bus     : qm_decode_stage_if.slave (fetch IR, writeback, controls in;
//             opcode/function/stall-fetch and ID/EX operands/controls out)
module qm_decode_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    parameter int ZERO_REG   = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    qm_decode_stage_if.slave     bus
);
    localparam int REG_AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    // Register fields; IR bits above REG_AW are ignored.
    logic [REG_AW-1:0] rs, rt, rd;
    assign rs = bus.di_IR[21 +: REG_AW];
    assign rt = bus.di_IR[16 +: REG_AW];
    assign rd = bus.di_IR[11 +: REG_AW];

    assign bus.o_Opcode   = bus.di_IR[31:26];
    assign bus.o_Function = bus.di_IR[5:0];

    // A write is real only if it targets an existing, writable register.
    logic wr_ok;
    assign wr_ok = bus.di_WE && !(ZERO_REG != 0 && bus.di_WA == '0)
                   && (int'(bus.di_WA) < REG_COUNT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[bus.di_WA] <= bus.di_WD;
        end
    end

    // Read ports: same-cycle writeback wins over the stored value, so a
    // capture coinciding with writeback never sees stale data.
    logic [DATA_WIDTH-1:0] rs_val, rt_val;
    always_comb begin
        rs_val = '0;
        if (wr_ok && bus.di_WA == rs)
            rs_val = bus.di_WD;
        else if (!(ZERO_REG != 0 && rs == '0) && int'(rs) < REG_COUNT)
            rs_val = regs[rs];
    end

    always_comb begin
        rt_val = '0;
        if (wr_ok && bus.di_WA == rt)
            rt_val = bus.di_WD;
        else if (!(ZERO_REG != 0 && rt == '0) && int'(rt) < REG_COUNT)
            rt_val = regs[rt];
    end

    logic [DATA_WIDTH-1:0] imm;
    assign imm = {{(DATA_WIDTH-16){bus.ci_ZeroExt ? 1'b0 : bus.di_IR[15]}},
                  bus.di_IR[15:0]};

    // Load in ID/EX whose destination feeds the instruction now in decode.
    // Not raised under ci_Stall: the stall already holds fetch and ID/EX.
    logic haz;
    assign haz = bus.do_Valid && bus.co_MemRead && !bus.ci_Stall
                 && (bus.do_RT != '0 || ZERO_REG == 0)
                 && (bus.do_RT == rs || bus.do_RT == rt)
                 && bus.di_IRValid;

    assign bus.o_StallFetch = haz || bus.ci_Stall;

    // ID/EX boundary: flush > stall > hazard bubble > capture.
    // Bubbles clear valid and controls only; data fields hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.do_RSVal      <= '0;
            bus.do_RTVal      <= '0;
            bus.do_Imm        <= '0;
            bus.do_RS         <= '0;
            bus.do_RT         <= '0;
            bus.do_RD         <= '0;
            bus.do_Valid      <= 1'b0;
            bus.co_RegWrite   <= 1'b0;
            bus.co_MemRead    <= 1'b0;
            bus.co_MemWrite   <= 1'b0;
            bus.co_ALUSource  <= 1'b0;
            bus.co_RegDest    <= 1'b0;
            bus.co_ALUControl <= '0;
        end else if (bus.ci_Flush || haz) begin
            bus.do_Valid      <= 1'b0;
            bus.co_RegWrite   <= 1'b0;
            bus.co_MemRead    <= 1'b0;
            bus.co_MemWrite   <= 1'b0;
            bus.co_ALUSource  <= 1'b0;
            bus.co_RegDest    <= 1'b0;
            bus.co_ALUControl <= '0;
        end else if (!bus.ci_Stall) begin
            bus.do_RSVal      <= rs_val;
            bus.do_RTVal      <= rt_val;
            bus.do_Imm        <= imm;
            bus.do_RS         <= rs;
            bus.do_RT         <= rt;
            bus.do_RD         <= rd;
            bus.do_Valid      <= bus.di_IRValid;
            bus.co_RegWrite   <= bus.di_IRValid & bus.ci_RegWrite;
            bus.co_MemRead    <= bus.di_IRValid & bus.ci_MemRead;
            bus.co_MemWrite   <= bus.di_IRValid & bus.ci_MemWrite;
            bus.co_ALUSource  <= bus.di_IRValid & bus.ci_ALUSource;
            bus.co_RegDest    <= bus.di_IRValid & bus.ci_RegDest;
            bus.co_ALUControl <= bus.di_IRValid ? bus.ci_ALUControl : 4'd0;
        end
    end
endmodule

// File: tb/tb_qm_decode_stage.sv
// tb_qm_decode_stage: directed scenarios plus randomized traffic for
// qm_decode_stage, checked against a behavioural model of the stage.
module tb_qm_decode_stage;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    qm_decode_stage_if #(.DATA_WIDTH(32), .REG_AW(5)) bus();

    qm_decode_stage #(.DATA_WIDTH(32), .REG_COUNT(32), .ZERO_REG(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Model of the ID/EX contents
    typedef struct {
        logic        v;
        logic [31:0] rsv, rtv, imm;
        logic [4:0]  rs, rt, rd;
        logic        rw, mr, mw, as, rdst;
        logic [3:0]  alu;
    } ex_t;

    ex_t         m;
    logic [31:0] mregs [32];
    int          n_chk = 0;
    int          n_fail = 0;
    logic        sf_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (bus.di_WE && bus.di_WA == a) return bus.di_WD;
        return mregs[a];
    endfunction

    function automatic logic [31:0] mkir(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        m = '{v: 1'b0, rsv: 32'd0, rtv: 32'd0, imm: 32'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0,
              rw: 1'b0, mr: 1'b0, mw: 1'b0, as: 1'b0, rdst: 1'b0, alu: 4'd0};
    endtask

    task automatic idle();
        bus.di_IR = 32'd0; bus.di_IRValid = 1'b0;
        bus.di_WA = 5'd0;  bus.di_WE = 1'b0; bus.di_WD = 32'd0;
        bus.ci_RegWrite = 1'b0; bus.ci_MemRead = 1'b0; bus.ci_MemWrite = 1'b0;
        bus.ci_ALUSource = 1'b0; bus.ci_RegDest = 1'b0; bus.ci_ZeroExt = 1'b0;
        bus.ci_ALUControl = 4'd0; bus.ci_Stall = 1'b0; bus.ci_Flush = 1'b0;
    endtask

    task automatic check_out();
        check("do_Valid", bus.do_Valid, m.v);
        check("co_ctrl", {bus.co_RegWrite, bus.co_MemRead, bus.co_MemWrite,
                          bus.co_ALUSource, bus.co_RegDest, bus.co_ALUControl},
                         {m.rw, m.mr, m.mw, m.as, m.rdst, m.alu});
        if (m.v) begin
            check("do_RSVal", bus.do_RSVal, m.rsv);
            check("do_RTVal", bus.do_RTVal, m.rtv);
            check("do_Imm", bus.do_Imm, m.imm);
            check("do_regs", {bus.do_RS, bus.do_RT, bus.do_RD}, {m.rs, m.rt, m.rd});
        end
    endtask

    // One clock: inputs are already applied. Checks combinational outputs,
    // predicts ID/EX from the stage rules, crosses the edge, checks ID/EX.
    task automatic step();
        logic [31:0] ir;
        logic [4:0]  rs, rt;
        logic        haz, irv;
        logic [15:0] i16;
        int          simm;
        ex_t         nx;
        #1;
        ir  = bus.di_IR;
        irv = bus.di_IRValid;
        rs  = ir[25:21];
        rt  = ir[20:16];
        haz = m.v && m.mr && !bus.ci_Stall && m.rt != 5'd0 && (m.rt == rs || m.rt == rt) && irv;
        sf_seen = bus.o_StallFetch;
        check("o_StallFetch", bus.o_StallFetch, haz || bus.ci_Stall);
        check("o_Opcode", bus.o_Opcode, ir[31:26]);
        check("o_Function", bus.o_Function, ir[5:0]);
        nx = m;
        if (bus.ci_Flush || haz) begin
            nx.v = 1'b0; nx.rw = 1'b0; nx.mr = 1'b0; nx.mw = 1'b0;
            nx.as = 1'b0; nx.rdst = 1'b0; nx.alu = 4'd0;
        end else if (!bus.ci_Stall) begin
            i16    = ir[15:0];
            simm   = $signed(i16);
            nx.v   = irv;
            nx.rsv = mread(rs);
            nx.rtv = mread(rt);
            nx.imm = bus.ci_ZeroExt ? {16'd0, i16} : simm;
            nx.rs  = rs; nx.rt = rt; nx.rd = ir[15:11];
            nx.rw  = irv && bus.ci_RegWrite;
            nx.mr  = irv && bus.ci_MemRead;
            nx.mw  = irv && bus.ci_MemWrite;
            nx.as  = irv && bus.ci_ALUSource;
            nx.rdst = irv && bus.ci_RegDest;
            nx.alu = irv ? bus.ci_ALUControl : 4'd0;
        end
        @(posedge clk);
        if (bus.di_WE && bus.di_WA != 5'd0) mregs[bus.di_WA] = bus.di_WD;
        m = nx;
        #1;
        check_out();
    endtask

    initial begin
        idle();
        model_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", {bus.do_RSVal, bus.do_RTVal}, 64'd0);
        check("rst_misc", {bus.do_Imm, bus.do_RS, bus.do_RT, bus.do_RD, bus.do_Valid,
                           bus.co_RegWrite, bus.co_MemRead, bus.co_ALUControl, bus.o_StallFetch}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Write r5 then read it back through rs
        bus.di_WE = 1'b1; bus.di_WA = 5'd5; bus.di_WD = 32'h1234_5678;
        step();
        idle();
        bus.di_IR = mkir(6'd0, 5'd5, 5'd0, 16'h2820); bus.di_IRValid = 1'b1; bus.ci_RegWrite = 1'b1;
        step();
        check("r5_read", {bus.do_Valid, bus.do_RSVal}, {1'b1, 32'h1234_5678});

        // Bypass of a same-cycle writeback
        idle();
        bus.di_WE = 1'b1; bus.di_WA = 5'd3; bus.di_WD = 32'hDEAD_BEEF;
        bus.di_IR = mkir(6'd0, 5'd3, 5'd5, 16'h0); bus.di_IRValid = 1'b1;
        step();
        check("bypass", bus.do_RSVal, 32'hDEAD_BEEF);

        // r0 ignores writes, including the bypass path
        idle();
        bus.di_WE = 1'b1; bus.di_WA = 5'd0; bus.di_WD = 32'd7;
        bus.di_IR = mkir(6'd0, 5'd0, 5'd0, 16'h0); bus.di_IRValid = 1'b1;
        step();
        check("r0_bypass", bus.do_RSVal, 32'd0);
        bus.di_WE = 1'b0;
        step();
        check("r0_read", bus.do_RSVal, 32'd0);

        // Immediate extension
        idle();
        bus.di_IR = mkir(6'h08, 5'd1, 5'd2, 16'h8001); bus.di_IRValid = 1'b1;
        step();
        check("imm_sext", bus.do_Imm, 32'hFFFF_8001);
        bus.ci_ZeroExt = 1'b1;
        step();
        check("imm_zext", bus.do_Imm, 32'h0000_8001);

        // Load-use: load to r4, then an instruction reading r4
        idle();
        bus.di_IR = mkir(6'h23, 5'd1, 5'd4, 16'h0010); bus.di_IRValid = 1'b1;
        bus.ci_MemRead = 1'b1; bus.ci_RegWrite = 1'b1;
        step();
        bus.di_IR = mkir(6'd0, 5'd4, 5'd2, 16'h1820); bus.ci_MemRead = 1'b0;
        step();
        check("lu_stall", sf_seen, 1'b1);
        check("lu_bubble", {bus.do_Valid, bus.co_RegWrite}, 2'b00);
        step();
        check("lu_release", sf_seen, 1'b0);
        check("lu_capture", {bus.do_Valid, bus.do_RS}, {1'b1, 5'd4});

        // Three-cycle stall with a changing IR, then flush+stall
        idle();
        bus.di_IR = mkir(6'd0, 5'd5, 5'd3, 16'h4000); bus.di_IRValid = 1'b1; bus.ci_RegWrite = 1'b1;
        step();
        bus.ci_Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.di_IR = mkir(6'd0, 5'(i + 9), 5'(i + 12), 16'(i * 3));
            step();
            check("stall_sf", sf_seen, 1'b1);
            check("stall_hold", {bus.do_RS, bus.do_RSVal}, {5'd5, 32'h1234_5678});
        end
        bus.ci_Flush = 1'b1;
        step();
        check("flush_stall", bus.do_Valid, 1'b0);

        // Asynchronous reset mid-cycle while ID/EX is live
        idle();
        bus.di_IR = mkir(6'd0, 5'd3, 5'd5, 16'h0); bus.di_IRValid = 1'b1; bus.ci_MemRead = 1'b1;
        step();
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", {bus.do_Valid, bus.co_MemRead, bus.o_StallFetch}, 3'b000);
        check("arst_data", {bus.do_RSVal, bus.do_RTVal}, 64'd0);
        model_reset();
        #2 reset_n = 1'b1;
        step();

        // Randomized traffic with register numbers clustered to provoke hazards
        for (int n = 0; n < 400; n++) begin
            bus.di_IR = $urandom();
            bus.di_IR[25:21] = 5'($urandom_range(0, 7));
            bus.di_IR[20:16] = 5'($urandom_range(0, 7));
            bus.di_IRValid   = ($urandom_range(0, 9) != 0);
            bus.di_WE        = $urandom_range(0, 1) == 1;
            bus.di_WA        = 5'($urandom_range(0, 7));
            bus.di_WD        = $urandom();
            bus.ci_RegWrite  = $urandom_range(0, 1) == 1;
            bus.ci_MemRead   = ($urandom_range(0, 2) == 0);
            bus.ci_MemWrite  = $urandom_range(0, 1) == 1;
            bus.ci_ALUSource = $urandom_range(0, 1) == 1;
            bus.ci_RegDest   = $urandom_range(0, 1) == 1;
            bus.ci_ZeroExt   = $urandom_range(0, 1) == 1;
            bus.ci_ALUControl = 4'($urandom_range(0, 15));
            bus.ci_Stall     = ($urandom_range(0, 6) == 0);
            bus.ci_Flush     = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
